silife_grid_write_arbiter: RTL and testbench

- Owns the single write/step port of the cell grid and shares it between three requesters:
  - the SPI grid loader: cell set/clear pulses, which cannot be stalled;
  - a host register interface: valid/ready row writes;
  - the generation timer: step requests.
- Guarantees the grid never sees a write and a generation step in the same cycle.
- Holds off steps while a load session is active.
- Sits between the loader/host/timer and the grid array.

---
 rtl/silife_pkg.sv | 26 ++
 rtl/silife_skid_buf1.sv | 42 ++++
 rtl/silife_grid_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_silife_grid_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared silife definitions: grid geometry defaults, write-arbiter FSM encoding
// and grant sources.
`timescale 1ns/1ps
package silife_pkg;

  localparam int GRID_WIDTH  = 32;
  localparam int GRID_HEIGHT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_GUARD   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_LOADER = 2'd1,
    GNT_HOST   = 2'd2,
    GNT_STEP   = 2'd3
  } grant_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/silife_skid_buf1.sv
// One-entry valid/ready holding register. Ready is simply "empty", so an accept
// and a drain can never land in the same cycle.
`timescale 1ns/1ps
module silife_skid_buf1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic full_q;
  logic accept;

  assign accept    = in_valid && in_ready;
  assign in_ready  = !full_q;
  assign out_valid = full_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
    end else if (out_ready) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the payload register is deliberately not reset; full_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/silife_grid_write_arbiter.sv
// Shares the grid's single write/step port between the SPI loader, the host
// register path and the generation timer; a step never coincides with a write.
`timescale 1ns/1ps
module silife_grid_write_arbiter
  import silife_pkg::*;
#(
  parameter  int WIDTH        = GRID_WIDTH,
  parameter  int HEIGHT       = GRID_HEIGHT,
  parameter  int GUARD_CYCLES = 4,
  localparam int ROW_BITS     = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ld_selected,
  input  logic [ROW_BITS-1:0] i_ld_row_select,
  input  logic [WIDTH-1:0]    i_ld_set_cells,
  input  logic [WIDTH-1:0]    i_ld_clear_cells,
  input  logic                i_host_valid,
  output logic                o_host_ready,
  input  logic [ROW_BITS-1:0] i_host_row,
  input  logic [WIDTH-1:0]    i_host_set,
  input  logic [WIDTH-1:0]    i_host_clear,
  input  logic                i_step_req,
  output logic [ROW_BITS-1:0] o_row_select,
  output logic [WIDTH-1:0]    o_set_cells,
  output logic [WIDTH-1:0]    o_clear_cells,
  output logic                o_step,
  output logic                o_loading,
  output logic [7:0]          o_step_missed
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

  typedef struct packed {
    logic [ROW_BITS-1:0] row;
    logic [WIDTH-1:0]    set;
    logic [WIDTH-1:0]    clear;
  } host_req_t;

  arb_state_e state_q, state_d;
  logic [7:0] guard_q, guard_d;
  logic       step_pending_q, step_pending_d;
  logic [7:0] missed_d;

  host_req_t  host_in, host_buf;
  logic       host_full, host_drain;
  logic       ld_wr;
  grant_e     gnt;

  logic [ROW_BITS-1:0] row_d;
  logic [WIDTH-1:0]    set_d, clear_d;
  logic                step_d;

  assign host_in = '{row: i_host_row, set: i_host_set, clear: i_host_clear};

  silife_skid_buf1 #(
    .DATA_W($bits(host_req_t))
  ) u_host_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (i_host_valid),
    .in_ready (o_host_ready),
    .in_data  (host_in),
    .out_valid(host_full),
    .out_ready(host_drain),
    .out_data (host_buf)
  );

  // Loader pulses cannot be stalled, so they win regardless of FSM state.
  assign ld_wr      = (|i_ld_set_cells) || (|i_ld_clear_cells);
  assign host_drain = (gnt == GNT_HOST);
  assign o_loading  = (state_q != ST_IDLE);

  always_comb begin
    gnt = GNT_NONE;
    if (ld_wr) begin
      gnt = GNT_LOADER;
    end else if (host_full) begin
      gnt = GNT_HOST;
    end else if ((state_q == ST_IDLE) && step_pending_q) begin
      gnt = GNT_STEP;
    end
  end

  // Load-session tracking: the guard window keeps steps off the grid until the
  // loader has been quiet for GUARD_CYCLES cycles.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_ld_selected) state_d = ST_LOADING;
      end
      ST_LOADING: begin
        if (!i_ld_selected) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        if (i_ld_selected) begin
          state_d = ST_LOADING;
          guard_d = 8'd0;
        end else if (guard_q <= 8'd1) begin
          state_d = ST_IDLE;
          guard_d = 8'd0;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        guard_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    row_d   = o_row_select;
    set_d   = '0;
    clear_d = '0;
    step_d  = 1'b0;
    unique case (gnt)
      GNT_LOADER: begin
        row_d   = i_ld_row_select;
        set_d   = i_ld_set_cells;
        clear_d = i_ld_clear_cells;
      end
      GNT_HOST: begin
        row_d   = host_buf.row;
        set_d   = host_buf.set;
        clear_d = host_buf.clear;
      end
      GNT_STEP: step_d = 1'b1;
      default: ;
    endcase
  end

  // A request landing on the cycle the pending step issues re-arms it cleanly.
  always_comb begin
    step_pending_d = step_pending_q;
    missed_d       = o_step_missed;
    if (i_step_req) begin
      step_pending_d = 1'b1;
      if (step_pending_q && (gnt != GNT_STEP)) missed_d = sat_inc8(o_step_missed);
    end else if (gnt == GNT_STEP) begin
      step_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      guard_q        <= 8'd0;
      step_pending_q <= 1'b0;
      o_step_missed  <= 8'd0;
      o_row_select   <= '0;
      o_set_cells    <= '0;
      o_clear_cells  <= '0;
      o_step         <= 1'b0;
    end else begin
      state_q        <= state_d;
      guard_q        <= guard_d;
      step_pending_q <= step_pending_d;
      o_step_missed  <= missed_d;
      o_row_select   <= row_d;
      o_set_cells    <= set_d;
      o_clear_cells  <= clear_d;
      o_step         <= step_d;
    end
  end

endmodule

// File: tb/tb_silife_grid_write_arbiter.sv
// Self-checking bench for silife_grid_write_arbiter: directed scenarios then
// random traffic, compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_silife_grid_write_arbiter;

  localparam int WIDTH    = 32;
  localparam int HEIGHT   = 32;
  localparam int GUARD    = 4;
  localparam int ROW_BITS = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                ld_sel;
  logic [ROW_BITS-1:0] ld_row;
  logic [WIDTH-1:0]    ld_set, ld_clr;
  logic                host_valid, host_ready;
  logic [ROW_BITS-1:0] host_row;
  logic [WIDTH-1:0]    host_set, host_clr;
  logic                step_req;
  logic [ROW_BITS-1:0] row_sel;
  logic [WIDTH-1:0]    set_cells, clr_cells;
  logic                step, loading;
  logic [7:0]          missed;

  always #5 clk = ~clk;

  silife_grid_write_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_ld_selected   (ld_sel),
    .i_ld_row_select (ld_row),
    .i_ld_set_cells  (ld_set),
    .i_ld_clear_cells(ld_clr),
    .i_host_valid    (host_valid),
    .o_host_ready    (host_ready),
    .i_host_row      (host_row),
    .i_host_set      (host_set),
    .i_host_clear    (host_clr),
    .i_step_req      (step_req),
    .o_row_select    (row_sel),
    .o_set_cells     (set_cells),
    .o_clear_cells   (clr_cells),
    .o_step          (step),
    .o_loading       (loading),
    .o_step_missed   (missed)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue for the host buffer, a sliding "loader seen
  // recently" window for step hold-off, and plain counters.
  typedef struct {
    logic [ROW_BITS-1:0] row;
    logic [WIDTH-1:0]    set;
    logic [WIDTH-1:0]    clr;
  } hreq_t;

  hreq_t               hq[$];
  bit                  m_pend;
  int                  m_missed;
  int                  cyc;
  int                  last_sel;
  logic [ROW_BITS-1:0] e_row;
  int                  step_count;

  task automatic model_reset();
    hq.delete();
    m_pend   = 1'b0;
    m_missed = 0;
    cyc      = 0;
    last_sel = -1000;
    e_row    = '0;
  endtask

  task automatic clear_pulses();
    ld_set     = '0;
    ld_clr     = '0;
    host_valid = 1'b0;
    step_req   = 1'b0;
  endtask

  // One clock: predict, clock, compare every output, drop one-cycle pulses.
  task automatic tick();
    bit          busy, wr, step_ok, was_empty, e_step;
    logic [31:0] e_set, e_clr;
    hreq_t       h;
    busy      = (cyc - last_sel) <= GUARD + 1;
    wr        = (ld_set != '0) || (ld_clr != '0);
    was_empty = (hq.size() == 0);
    step_ok   = !busy && !wr && was_empty && m_pend;
    e_step    = 1'b0;
    e_set     = '0;
    e_clr     = '0;
    if (wr) begin
      e_row = ld_row; e_set = ld_set; e_clr = ld_clr;
    end else if (!was_empty) begin
      h = hq.pop_front();
      e_row = h.row; e_set = h.set; e_clr = h.clr;
    end else if (step_ok) begin
      e_step = 1'b1;
    end
    if (step_req && m_pend && !step_ok) m_missed = (m_missed < 255) ? m_missed + 1 : 255;
    if (step_req) m_pend = 1'b1;
    else if (step_ok) m_pend = 1'b0;
    if (host_valid && was_empty) begin
      h.row = host_row; h.set = host_set; h.clr = host_clr;
      hq.push_back(h);
    end
    if (ld_sel) last_sel = cyc;
    cyc++;
    @(posedge clk);
    #1;
    check($sformatf("row@%0d", cyc), 32'(row_sel), 32'(e_row));
    check($sformatf("set@%0d", cyc), set_cells, e_set);
    check($sformatf("clr@%0d", cyc), clr_cells, e_clr);
    check($sformatf("step@%0d", cyc), 32'(step), 32'(e_step));
    check($sformatf("loading@%0d", cyc), 32'(loading), 32'((cyc - last_sel) <= GUARD + 1));
    check($sformatf("ready@%0d", cyc), 32'(host_ready), 32'(hq.size() == 0));
    check($sformatf("missed@%0d", cyc), 32'(missed), 32'(m_missed));
    if (step) step_count++;
    clear_pulses();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_row"},     32'(row_sel),    32'd0);
    check({tag, "_set"},     set_cells,       32'd0);
    check({tag, "_clr"},     clr_cells,       32'd0);
    check({tag, "_step"},    32'(step),       32'd0);
    check({tag, "_loading"}, 32'(loading),    32'd0);
    check({tag, "_ready"},   32'(host_ready), 32'd1);
    check({tag, "_missed"},  32'(missed),     32'd0);
  endtask

  initial begin : stimulus
    int base, seen_at;

    reset = 1'b1;
    ld_sel = 1'b0; ld_row = '0; host_row = '0; host_set = '0; host_clr = '0;
    clear_pulses();
    model_reset();
    step_count = 0;
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Host-only write, then a host write with overlapping set/clear bits.
    host_valid = 1'b1; host_row = 5'd5; host_set = 32'h1; host_clr = 32'h2;
    tick();
    check("host_ready_low", 32'(host_ready), 32'd0);
    tick();
    check("host_row", 32'(row_sel), 32'd5);
    check("host_set", set_cells, 32'h1);
    check("host_clr", clr_cells, 32'h2);
    tick();
    check("host_ready_back", 32'(host_ready), 32'd1);
    host_valid = 1'b1; host_row = 5'd9; host_set = 32'hF0; host_clr = 32'hF0;
    ticks(2);
    check("host_overlap_set", set_cells, 32'hF0);
    check("host_overlap_clr", clr_cells, 32'hF0);

    // Loader pulse collides with a buffered host entry.
    host_valid = 1'b1; host_row = 5'd7; host_set = 32'h00FF; host_clr = 32'h0;
    tick();
    ld_row = 5'd3; ld_set = 32'h8000_0000;
    tick();
    check("coll_ld_row", 32'(row_sel), 32'd3);
    check("coll_ld_set", set_cells, 32'h8000_0000);
    check("coll_ready_held", 32'(host_ready), 32'd0);
    tick();
    check("coll_host_row", 32'(row_sel), 32'd7);
    check("coll_host_set", set_cells, 32'h00FF);
    ticks(2);

    // Load hold-off: a step requested mid-session waits out the guard window.
    base = step_count;
    ld_sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step_req = 1'b1;
      tick();
    end
    ld_sel = 1'b0;
    seen_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step && seen_at < 0) seen_at = i;
    end
    check("holdoff_step_tick", 32'(seen_at), 32'(GUARD + 2));
    check("holdoff_step_count", 32'(step_count - base), 32'd1);

    // Guard re-entry: loader returns two cycles after deselecting.
    base = step_count;
    ld_sel = 1'b1; step_req = 1'b1;
    ticks(3);
    ld_sel = 1'b0;
    ticks(2);
    ld_sel = 1'b1;
    tick();
    check("reentry_loading", 32'(loading), 32'd1);
    ticks(3);
    check("reentry_no_step", 32'(step_count - base), 32'd0);
    ld_sel = 1'b0;
    ticks(10);
    check("reentry_one_step", 32'(step_count - base), 32'd1);

    // Missed steps: three requests in one session, then saturation.
    base = step_count;
    ld_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1; tick(); tick();
    end
    ld_sel = 1'b0;
    ticks(10);
    check("missed_two", 32'(missed), 32'd2);
    check("missed_one_step", 32'(step_count - base), 32'd1);
    ld_sel = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step_req = 1'b1; tick();
    end
    check("missed_saturated", 32'(missed), 32'd255);
    ld_sel = 1'b0;
    ticks(10);

    // Reset mid-operation: a buffered host entry and a pending step are dropped.
    ld_sel = 1'b1; step_req = 1'b1;
    tick();
    host_valid = 1'b1; host_row = 5'd12; host_set = 32'hA5A5; host_clr = 32'h0;
    ld_set = 32'h1;
    tick();
    reset = 1'b1;
    ld_sel = 1'b0;
    #2;
    check_reset_state("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    base = step_count;
    ticks(10);
    check("midreset_no_replay", 32'(step_count - base), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) ld_sel = ~ld_sel;
      if ($urandom_range(0, 4) == 0) begin
        ld_row = 5'($urandom());
        ld_set = $urandom() & $urandom();
        ld_clr = ($urandom_range(0, 1) == 1) ? $urandom() : 32'h0;
      end
      if ($urandom_range(0, 2) == 0) begin
        host_valid = 1'b1;
        host_row = 5'($urandom());
        host_set = $urandom();
        host_clr = $urandom();
      end
      step_req = ($urandom_range(0, 6) == 0);
      tick();
    end
    ld_sel = 1'b0;
    ticks(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
